uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, clocks per UART bit (1 MHz mclk / 9600 baud); legal range 4..4095.
REQ-002 Parameter DEPTH, default 4, receive FIFO depth in bytes; power of two, 2..16.
REQ-003 clk  input  1  single clock (mclk domain); all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx  input  1  asynchronous UART serial line (board RX pin); idle high; 8N1 frame, LSB first.
REQ-006 rd_en  input  1  pop request from com_block; one byte per asserted cycle.
REQ-007 clr_err  input  1  clears sticky error flags.
REQ-008 data  output  8  FIFO head byte, first-word fall-through.
REQ-009 valid  output  1  FIFO non-empty; data is meaningful only while high.
REQ-010 full  output  1  FIFO holds DEPTH bytes.
REQ-011 overrun  output  1  sticky: a received byte was dropped because the FIFO was full.
REQ-012 frame_err  output  1  sticky: a stop bit sampled low.
REQ-013 irq  output  1  valid OR overrun OR frame_err; drives com_block interrupt path.

Function
REQ-014 rx SHALL pass a 2-flop synchronizer (flops reset to 1); the FSM SHALL see only the synchronized value rx_s.
REQ-015 FSM states IDLE, START, DATA, STOP; one bit counter (0..CLKS_PER_BIT-1), one 3-bit index.
REQ-016 IDLE: rx_s==0 -> START, bit counter cleared.
REQ-017 START: after CLKS_PER_BIT/2 cycles (integer division) sample rx_s; 0 -> DATA with counter cleared; 1 -> IDLE (glitch rejected, no flag, no push).
REQ-018 DATA: every CLKS_PER_BIT cycles sample rx_s into shift register bit [index], LSB first; after bit 7 -> STOP.
REQ-019 STOP: after CLKS_PER_BIT cycles sample rx_s; 1 -> push byte; 0 -> set frame_err, discard byte; both -> IDLE same cycle.
REQ-020 Pushed byte SHALL appear on data with valid high on the cycle after the stop-bit sample when FIFO was empty.
REQ-021 Back-to-back frames: a start edge arriving immediately after the stop-bit sample SHALL be detected without loss.
REQ-022 Push while full and no pop -> byte dropped, overrun set, FIFO contents unchanged.
REQ-023 Push and pop in same cycle when full -> both performed, count stays DEPTH, overrun not set.
REQ-024 Push and pop in same cycle when empty -> push performed only; valid high next cycle.
REQ-025 rd_en while empty SHALL be ignored; pointers unchanged.
REQ-026 Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-027 clr_err clears overrun and frame_err next cycle; a simultaneous new error event wins (flag remains set).
REQ-028 irq SHALL be combinational from registered valid/overrun/frame_err; no other output depends combinationally on inputs.

Reset
REQ-029 rst_n low SHALL, asynchronously: FSM to IDLE, counters 0, shift register 0, FIFO empty, valid/full/overrun/frame_err/irq 0, data 0x00, synchronizer flops 1.
REQ-030 Reset mid-frame SHALL abandon the partial byte; after release the first frame whose start edge follows release SHALL be received correctly.

Structure
REQ-031 Shared package uart_pkg SHALL hold the state enum typedef (uart_rx_state_t) and the default CLKS_PER_BIT constant; the uart_tx block reuses it.
REQ-032 FIFO SHALL be a separate sub-module uart_fifo (parameter DEPTH, width 8, push/pop/data/empty/full); FSM and synchronizer remain in uart_rx.

Verification (bench uses CLKS_PER_BIT=8, DEPTH=4)
REQ-033 Send 0xA5 8N1 -> valid rises exactly 2 (sync) + 4 + 8*8 + 8 + 1 cycles after rx falls, data=0xA5, irq=1; rd_en one cycle -> valid=0.
REQ-034 Send 0x01,0x02,0x03,0x04,0x05 with no pops -> full=1 after 4th, overrun=1 after 5th, pops return 0x01..0x04 in order.
REQ-035 Send 0x3C with stop bit driven low -> frame_err=1, valid stays 0; clr_err pulse -> frame_err=0, irq=0.
REQ-036 rx low pulse of 3 cycles then high -> no push, no flags, FSM back to IDLE.
REQ-037 FIFO full, hold rd_en during 5th frame's stop sample -> overrun=0, count=4, head advanced to 0x02.
REQ-038 Assert rst_n low at DATA bit 4 of 0x55, release, send 0x99 -> only 0x99 received, flags 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default bit timing.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_rx_state_t;

    // 1 MHz mclk / 9600 baud
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 104;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with first-word fall-through read port; pops while empty are ignored and
// pushes while full are dropped unless a pop happens in the same cycle.
module uart_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CountFull = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CountFull);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push needs
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: input synchronizer, centre-sampling FSM, receive FIFO and sticky
// overrun / framing error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned DEPTH        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] data,
    output logic       valid,
    output logic       full,
    output logic       overrun,
    output logic       frame_err,
    output logic       irq
);

    localparam logic [11:0] BitLast  = 12'(CLKS_PER_BIT - 1);
    localparam logic [11:0] HalfLast = 12'(CLKS_PER_BIT / 2 - 1);

    logic           rx_meta_q;
    logic           rx_s;
    uart_rx_state_t state_q, state_d;
    logic [11:0]    cnt_q, cnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           push;
    logic           frame_evt;
    logic           overrun_evt;
    logic           overrun_q, frame_err_q;
    logic           fifo_empty;
    logic           fifo_full;

    // Synchronizer flops idle high so reset never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s      <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_evt = 1'b0;
        case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d     = '0;
                    state_d   = StIdle;
                    push      = rx_s;
                    frame_evt = ~rx_s;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    uart_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (rd_en),
        .wdata (shift_q),
        .rdata (data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // A full FIFO is never empty, so rd_en here always means a real pop
    assign overrun_evt = push & fifo_full & ~rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= (overrun_q & ~clr_err) | overrun_evt;
            frame_err_q <= (frame_err_q & ~clr_err) | frame_evt;
        end
    end

    assign valid     = ~fifo_empty;
    assign full      = fifo_full;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign irq       = valid | overrun_q | frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of single frames plus hand-written sequences
// for latency, FIFO full/overrun, glitch rejection and mid-frame reset.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned CPB = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data;
    logic       valid, full, overrun, frame_err, irq;

    int n_total = 0;
    int n_pass  = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[5];

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .data      (data),
        .valid     (valid),
        .full      (full),
        .overrun   (overrun),
        .frame_err (frame_err),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // All tasks start and end 1 time unit after a rising edge
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string name);
        logic [7:0] e;
        check({name, "_sb"}, (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        check({name, "_valid"}, 32'(valid), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        check({name, "_data"}, 32'(data), 32'(e));
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
    endtask

    // Frame with rd_en held across the stop-bit sample edge (79 edges after start)
    task automatic send_with_pop(input logic [7:0] b);
        fork
            send_frame(b, 1'b1);
            begin
                repeat (78) @(posedge clk);
                #1;
                rd_en = 1'b1;
                @(posedge clk);
                #1;
                rd_en = 1'b0;
            end
        join
    endtask

    initial begin
        int lat;
        vecs[0] = '{b: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
        vecs[1] = '{b: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
        vecs[2] = '{b: 8'h3C, stop: 1'b0, exp_valid: 1'b0, exp_ferr: 1'b1};
        vecs[3] = '{b: 8'h5A, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
        vecs[4] = '{b: 8'h81, stop: 1'b0, exp_valid: 1'b0, exp_ferr: 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid), 0);
        check("rst_full", 32'(full), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_data", 32'(data), 0);
        rst_n = 1'b1;
        idle(2);

        // Latency of a single frame
        exp_q.push_back(8'hA5);
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int k = 1; k <= 200; k++) begin
                    @(posedge clk);
                    #2;
                    if (valid) begin
                        lat = k;
                        break;
                    end
                end
            end
        join
        check("a5_latency", 32'(lat), 79);
        check("a5_irq", 32'(irq), 1);
        pop_check("a5");
        check("a5_valid_after_pop", 32'(valid), 0);
        check("a5_irq_after_pop", 32'(irq), 0);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].exp_valid) exp_q.push_back(vecs[i].b);
            send_frame(vecs[i].b, vecs[i].stop);
            idle(16);
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_ferr", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_valid | vecs[i].exp_ferr));
            if (vecs[i].exp_valid) pop_check($sformatf("vec%0d", i));
            if (vecs[i].exp_ferr) begin
                pulse_clr();
                check($sformatf("vec%0d_ferr_clr", i), 32'(frame_err), 0);
                check($sformatf("vec%0d_irq_clr", i), 32'(irq), 0);
            end
        end

        // Short low glitch is rejected; rd_en while empty is ignored
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        rd_en = 1'b1;
        idle(2);
        rd_en = 1'b0;
        idle(20);
        check("glitch_valid", 32'(valid), 0);
        check("glitch_ferr", 32'(frame_err), 0);
        check("glitch_overrun", 32'(overrun), 0);
        check("glitch_state", 32'(dut.state_q), 32'(StIdle));

        // Push and pop in the same cycle while empty: push wins
        exp_q.push_back(8'h6E);
        send_with_pop(8'h6E);
        check("pp_empty_valid", 32'(valid), 1);
        pop_check("pp_empty");

        // Back-to-back frames fill the FIFO then overrun
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
            if (i == 3) check("fill_not_full3", 32'(full), 0);
            if (i == 4) check("fill_full4", 32'(full), 1);
            if (i == 4) check("fill_no_ovr4", 32'(overrun), 0);
        end
        idle(2);
        check("ovr_set", 32'(overrun), 1);
        check("ovr_full", 32'(full), 1);
        for (int i = 1; i <= 4; i++) pop_check($sformatf("ovr_pop%0d", i));
        check("ovr_empty", 32'(valid), 0);
        pulse_clr();
        check("ovr_clr", 32'(overrun), 0);

        // Pop during the stop sample of a fifth frame while full: no overrun
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        exp_q.push_back(8'h05);
        check("ppf_head1", 32'(data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
        send_with_pop(8'h05);
        idle(2);
        check("ppf_overrun", 32'(overrun), 0);
        check("ppf_full", 32'(full), 1);
        for (int i = 2; i <= 5; i++) pop_check($sformatf("ppf_pop%0d", i));
        check("ppf_empty", 32'(valid), 0);

        // Reset during data bit 4 of 0x55
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h55 >> i));
        rx = 1'b1;
        idle(4);
        rst_n = 1'b0;
        idle(2);
        check("mid_rst_state", 32'(dut.state_q), 32'(StIdle));
        check("mid_rst_valid", 32'(valid), 0);
        rst_n = 1'b1;
        idle(4);
        exp_q.push_back(8'h99);
        send_frame(8'h99, 1'b1);
        idle(2);
        check("mid_rst_ferr", 32'(frame_err), 0);
        check("mid_rst_ovr", 32'(overrun), 0);
        pop_check("mid_rst");
        check("mid_rst_only_one", 32'(valid), 0);
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
